// File: rtl/pos_sentence_collector_if.sv
// Tagger-side and reader-side signals of the sentence collector, bundled as one interface.
// The master modport is the environment (tagger and reader); the slave modport is the collector.
interface pos_sentence_collector_if #(
  parameter int word_num_bit = 4,
  parameter int POS_num_bit  = 4,
  parameter int depth_bit    = 4
);
  logic                    tag_valid;
  logic [word_num_bit-1:0] key;
  logic [POS_num_bit-1:0]  final_POS;
  logic                    endline;
  logic                    error;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [word_num_bit-1:0] rd_key;
  logic [POS_num_bit-1:0]  rd_pos;
  logic                    rd_last;
  logic [depth_bit:0]      sentence_count;
  logic                    busy;
  logic                    sent_dropped;
  logic                    overflow;

  modport master (
    output tag_valid, key, final_POS, endline, error, rd_ready,
    input  rd_valid, rd_key, rd_pos, rd_last, sentence_count, busy, sent_dropped, overflow
  );

  modport slave (
    input  tag_valid, key, final_POS, endline, error, rd_ready,
    output rd_valid, rd_key, rd_pos, rd_last, sentence_count, busy, sent_dropped, overflow
  );
endinterface

// File: rtl/pos_sentence_collector.sv
// Collects (key, POS) pairs into sentences and releases only whole, committed sentences
// to the reader; aborted or overflowing sentences are rolled back to the last commit point.
module pos_sentence_collector #(
  parameter int word_num_bit = 4,
  parameter int POS_num_bit  = 4,
  parameter int depth_bit    = 4
) (
  input logic                   clk,
  input logic                   reset,
  pos_sentence_collector_if.slave bus
);

  localparam int DEPTH = 1 << depth_bit;
  localparam int PW    = depth_bit + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DROP} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_commit_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW-1:0]           r_sentence_count;
  logic                    r_sent_dropped;
  logic                    r_overflow;

  logic [word_num_bit-1:0] r_mem_key [DEPTH];
  logic [POS_num_bit-1:0]  r_mem_pos [DEPTH];
  logic [DEPTH-1:0]        r_mem_last;

  logic                    w_full;
  logic                    w_wr_en;
  logic                    w_commit;
  logic                    w_abort;
  logic                    w_ovf_set;
  logic                    w_mark_prev;
  logic                    w_rd_valid;
  logic                    w_pop;
  logic                    w_pop_last;
  logic [PW-1:0]           w_occupancy;
  logic [PW-1:0]           w_prev_ptr;
  logic [depth_bit-1:0]    w_wr_idx;
  logic [depth_bit-1:0]    w_prev_idx;
  logic [depth_bit-1:0]    w_rd_idx;

  // The extra pointer MSB tells a full buffer apart from an empty one.
  assign w_occupancy = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_occupancy == PW'(DEPTH));
  assign w_prev_ptr  = r_wr_ptr - PW'(1);
  assign w_wr_idx    = r_wr_ptr[depth_bit-1:0];
  assign w_prev_idx  = w_prev_ptr[depth_bit-1:0];
  assign w_rd_idx    = r_rd_ptr[depth_bit-1:0];

  assign w_rd_valid  = (r_rd_ptr != r_commit_ptr);
  assign w_pop       = w_rd_valid & bus.rd_ready;
  assign w_pop_last  = w_pop & r_mem_last[w_rd_idx];

  // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    w_commit     = 1'b0;
    w_abort      = 1'b0;
    w_ovf_set    = 1'b0;
    w_mark_prev  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.tag_valid) begin
          if (bus.error) begin
            w_abort = 1'b1;
          end else if (w_full) begin
            w_ovf_set = 1'b1;
            if (bus.endline) w_abort = 1'b1;
            else             w_next_state = S_DROP;
          end else begin
            w_wr_en = 1'b1;
            if (bus.endline) w_commit = 1'b1;
            else             w_next_state = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (bus.error) begin
          w_abort = 1'b1;
        end else if (bus.tag_valid && w_full) begin
          w_ovf_set = 1'b1;
          if (bus.endline) w_abort = 1'b1;
          else             w_next_state = S_DROP;
        end else if (bus.endline) begin
          w_commit = 1'b1;
          // An endline without a word closes the sentence on the entry already written.
          if (bus.tag_valid) w_wr_en = 1'b1;
          else               w_mark_prev = 1'b1;
        end else if (bus.tag_valid) begin
          w_wr_en = 1'b1;
        end
      end
      S_DROP: begin
        if (bus.error || bus.endline) w_abort = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_abort || w_commit) w_next_state = S_IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_wr_ptr         <= '0;
      r_commit_ptr     <= '0;
      r_rd_ptr         <= '0;
      r_sentence_count <= '0;
      r_sent_dropped   <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_sent_dropped <= w_abort;
      if (w_ovf_set) r_overflow <= 1'b1;

      if (w_abort)      r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);

      if (w_commit) r_commit_ptr <= w_wr_en ? r_wr_ptr + PW'(1) : r_wr_ptr;

      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);

      if (w_commit && !w_pop_last)      r_sentence_count <= r_sentence_count + PW'(1);
      else if (!w_commit && w_pop_last) r_sentence_count <= r_sentence_count - PW'(1);
    end
  end

  // NOTE: storage carries no reset; entries are only visible between rd_ptr and commit_ptr, which reset empties.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_key[w_wr_idx]  <= bus.key;
      r_mem_pos[w_wr_idx]  <= bus.final_POS;
      r_mem_last[w_wr_idx] <= bus.endline;
    end else if (w_mark_prev) begin
      r_mem_last[w_prev_idx] <= 1'b1;
    end
  end

  // Read data is forced to zero when nothing is committed so stale storage never leaks out.
  assign bus.rd_valid       = w_rd_valid;
  assign bus.rd_key         = w_rd_valid ? r_mem_key[w_rd_idx] : '0;
  assign bus.rd_pos         = w_rd_valid ? r_mem_pos[w_rd_idx] : '0;
  assign bus.rd_last        = w_rd_valid & r_mem_last[w_rd_idx];
  assign bus.sentence_count = r_sentence_count;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.sent_dropped   = r_sent_dropped;
  assign bus.overflow       = r_overflow;

endmodule

// File: tb/tb_pos_sentence_collector.sv
// Directed bench for pos_sentence_collector: a queue-based sentence model is compared every
// cycle, and literal expectations pin the key scenarios.
module tb_pos_sentence_collector;

  localparam int DEPTH = 16;

  typedef struct {
    logic [3:0] key;
    logic [3:0] pos;
    logic       last;
  } ent_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  bit   chk_en;

  pos_sentence_collector_if #(.word_num_bit(4), .POS_num_bit(4), .depth_bit(4)) iface ();

  pos_sentence_collector #(.word_num_bit(4), .POS_num_bit(4), .depth_bit(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (iface.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed-unread entries, the sentence being assembled, and a drop flag.
  ent_t       m_q[$];
  ent_t       m_pend[$];
  bit         m_drop;
  bit         m_ovf;
  bit         m_dropped;
  int         m_sent;

  task automatic model_reset();
    m_q.delete();
    m_pend.delete();
    m_drop    = 0;
    m_ovf     = 0;
    m_dropped = 0;
    m_sent    = 0;
  endtask

  task automatic model_step();
    bit   pop, full, commit, dropped, busy;
    ent_t e;
    pop     = (m_q.size() > 0) && iface.rd_ready;
    full    = (m_q.size() + m_pend.size()) == DEPTH;
    busy    = (m_pend.size() > 0) || m_drop;
    commit  = 0;
    dropped = 0;
    if (iface.error && (busy || iface.tag_valid)) begin
      m_pend.delete();
      m_drop  = 0;
      dropped = 1;
    end else if (m_drop) begin
      if (iface.endline) begin
        m_pend.delete();
        m_drop  = 0;
        dropped = 1;
      end
    end else if (iface.tag_valid) begin
      if (full) begin
        m_ovf = 1;
        if (iface.endline) begin
          m_pend.delete();
          dropped = 1;
        end else begin
          m_drop = 1;
        end
      end else begin
        e.key  = iface.key;
        e.pos  = iface.final_POS;
        e.last = iface.endline;
        m_pend.push_back(e);
        commit = iface.endline;
      end
    end else if (iface.endline && m_pend.size() > 0) begin
      e      = m_pend[m_pend.size()-1];
      e.last = 1;
      m_pend[m_pend.size()-1] = e;
      commit = 1;
    end
    if (pop) begin
      e = m_q.pop_front();
      if (e.last) m_sent--;
    end
    if (commit) begin
      foreach (m_pend[i]) m_q.push_back(m_pend[i]);
      m_pend.delete();
      m_sent++;
    end
    m_dropped = dropped;
  endtask

  task automatic compare();
    bit exp_valid;
    exp_valid = m_q.size() > 0;
    check("rd_valid", 32'(iface.rd_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("rd_key",  32'(iface.rd_key),  32'(m_q[0].key));
      check("rd_pos",  32'(iface.rd_pos),  32'(m_q[0].pos));
      check("rd_last", 32'(iface.rd_last), 32'(m_q[0].last));
    end else begin
      check("rd_last_idle", 32'(iface.rd_last), 32'd0);
    end
    check("sentence_count", 32'(iface.sentence_count), 32'(m_sent));
    check("busy",           32'(iface.busy),           32'((m_pend.size() > 0) || m_drop));
    check("sent_dropped",   32'(iface.sent_dropped),   32'(m_dropped));
    check("overflow",       32'(iface.overflow),       32'(m_ovf));
  endtask

  // Inputs are stable from one edge+1 to the next, so at each falling edge they are exactly what the next rising edge samples.
  initial begin
    model_reset();
    wait (chk_en);
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      compare();
      if (reset) model_step();
    end
  end

  task automatic drive(input logic tv, input logic [3:0] k, input logic [3:0] p,
                       input logic el, input logic er, input logic rr);
    iface.tag_valid = tv;
    iface.key       = k;
    iface.final_POS = p;
    iface.endline   = el;
    iface.error     = er;
    iface.rd_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int   popped;
  logic [3:0] k_t;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    iface.tag_valid = 0; iface.key = 0; iface.final_POS = 0;
    iface.endline = 0; iface.error = 0; iface.rd_ready = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_valid", 32'(iface.rd_valid), 32'd0);
    check("reset_count",    32'(iface.sentence_count), 32'd0);
    reset = 1'b1;

    // Basic three-word sentence with an always-ready reader.
    drive(1, 4'd1, 4'd4, 0, 0, 1);
    check("t1_busy", 32'(iface.busy), 32'd1);
    drive(1, 4'd2, 4'd5, 0, 0, 1);
    check("t1_not_visible", 32'(iface.rd_valid), 32'd0);
    drive(1, 4'd3, 4'd6, 1, 0, 1);
    check("t1_valid", 32'(iface.rd_valid), 32'd1);
    check("t1_key1",  32'(iface.rd_key), 32'd1);
    check("t1_pos1",  32'(iface.rd_pos), 32'd4);
    check("t1_last1", 32'(iface.rd_last), 32'd0);
    check("t1_cnt1",  32'(iface.sentence_count), 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    check("t1_key2",  32'(iface.rd_key), 32'd2);
    check("t1_pos2",  32'(iface.rd_pos), 32'd5);
    drive(0, 0, 0, 0, 0, 1);
    check("t1_key3",  32'(iface.rd_key), 32'd3);
    check("t1_last3", 32'(iface.rd_last), 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    check("t1_empty", 32'(iface.rd_valid), 32'd0);
    check("t1_cnt0",  32'(iface.sentence_count), 32'd0);

    // Error aborts the sentence; a lone endline afterwards is a no-op.
    drive(1, 4'd7, 4'd1, 0, 0, 0);
    drive(1, 4'd8, 4'd2, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("t2_dropped", 32'(iface.sent_dropped), 32'd1);
    check("t2_idle",    32'(iface.busy), 32'd0);
    drive(0, 0, 0, 1, 0, 0);
    check("t2_pulse_end", 32'(iface.sent_dropped), 32'd0);
    check("t2_no_valid",  32'(iface.rd_valid), 32'd0);
    drive(1, 4'd9, 4'd3, 1, 0, 0);
    check("t2_key9",  32'(iface.rd_key), 32'd9);
    check("t2_last9", 32'(iface.rd_last), 32'd1);
    check("t2_cnt1",  32'(iface.sentence_count), 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    check("t2_cnt0",  32'(iface.sentence_count), 32'd0);

    // Seventeen words into a sixteen-entry buffer with no reader.
    for (int i = 0; i < 17; i++) drive(1, 4'(i), 4'(15 - i), (i == 16), 0, 0);
    check("t3_overflow", 32'(iface.overflow), 32'd1);
    check("t3_dropped",  32'(iface.sent_dropped), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    check("t3_no_valid", 32'(iface.rd_valid), 32'd0);
    check("t3_cnt0",     32'(iface.sentence_count), 32'd0);

    // Three six-word sentences, reader ready every third cycle; pointers wrap.
    popped = 0;
    for (int c = 0; c < 200 && popped < 18; c++) begin
      iface.tag_valid = (c < 18);
      iface.key       = 4'(c + 1);
      iface.final_POS = 4'((c + 1) * 3);
      iface.endline   = (c < 18) && (((c + 1) % 6) == 0);
      iface.error     = 0;
      iface.rd_ready  = ((c % 3) == 2);
      #2;
      if (iface.rd_valid && iface.rd_ready) begin
        popped++;
        k_t = 4'(popped);
        check("t4_key",  32'(iface.rd_key),  32'(k_t));
        check("t4_last", 32'(iface.rd_last), 32'((popped % 6) == 0));
      end
      @(posedge clk);
      #1;
    end
    check("t4_popped", 32'(popped), 32'd18);
    check("t4_cnt0",   32'(iface.sentence_count), 32'd0);

    // Error with endline on the final word aborts; a prior committed sentence survives.
    drive(1, 4'd5, 4'd1, 1, 0, 0);
    drive(1, 4'd6, 4'd2, 0, 0, 0);
    drive(1, 4'd7, 4'd3, 0, 0, 0);
    drive(1, 4'd8, 4'd4, 1, 1, 0);
    check("t5_dropped", 32'(iface.sent_dropped), 32'd1);
    check("t5_cnt1",    32'(iface.sentence_count), 32'd1);
    check("t5_key5",    32'(iface.rd_key), 32'd5);
    drive(0, 0, 0, 0, 0, 0);
    check("t5_pulse_end", 32'(iface.sent_dropped), 32'd0);

    // Asynchronous reset in the middle of a sentence with one unread sentence.
    drive(1, 4'd10, 4'd1, 0, 0, 0);
    drive(1, 4'd11, 4'd2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    check("t6_valid",    32'(iface.rd_valid), 32'd0);
    check("t6_cnt",      32'(iface.sentence_count), 32'd0);
    check("t6_busy",     32'(iface.busy), 32'd0);
    check("t6_overflow", 32'(iface.overflow), 32'd0);
    check("t6_last",     32'(iface.rd_last), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_hold_valid", 32'(iface.rd_valid), 32'd0);
    check("t6_hold_busy",  32'(iface.busy), 32'd0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    check("t6_after_valid", 32'(iface.rd_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pos_sentence_collector.md
Name: pos_sentence_collector

Overview:
- Receiving end of the tagger output stream: accepts (key, final_POS) word-tag pairs from the Viterbi core, assembles them into sentences delimited by endline, and exposes only complete sentences to a downstream reader through a valid/ready port.
- A sentence aborted by error, or one that overflows the buffer, is discarded atomically. The reader never sees a partial sentence.

Parameters:
word_num_bit, 4, width of the word index (key)
POS_num_bit, 4, width of a POS tag
depth_bit, 4, log2 of buffer depth; DEPTH = 2**depth_bit entries (default 16)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
tag_valid  input  1  one word-tag pair presented this cycle
key  input  word_num_bit  word index of the presented pair
final_POS  input  POS_num_bit  decoded tag of the presented pair
endline  input  1  current pair, or the pending sentence if tag_valid=0, ends the sentence
error  input  1  upstream error; abort the sentence in progress
rd_valid  output  1  committed entry available
rd_ready  input  1  reader accepts the entry this cycle
rd_key  output  word_num_bit  key of the head entry
rd_pos  output  POS_num_bit  tag of the head entry
rd_last  output  1  head entry is the last word of its sentence
sentence_count  output  depth_bit+1  complete sentences still unread
busy  output  1  sentence in progress (state != IDLE)
sent_dropped  output  1  one-cycle pulse: a sentence was discarded
overflow  output  1  sticky; set on any dropped word, cleared only by reset

Behaviour:
- Storage is DEPTH entries of {key, pos, last}. Pointers wr_ptr, commit_ptr and rd_ptr are depth_bit+1 bits wide and wrap naturally.
- Occupancy is wr_ptr - rd_ptr. full = occupancy == DEPTH.
- Reset (reset=0, async): all pointers 0, state IDLE, rd_valid=0, rd_last=0, sentence_count=0, busy=0, sent_dropped=0, overflow=0. Buffer contents are don't-care.
- A reset mid-sentence or mid-read discards everything.
- State machine:
  - IDLE: tag_valid & !error writes the entry, goes to COLLECT, or commits immediately if endline is also high. endline alone with no words is a no-op.
  - COLLECT: each tag_valid & !error & !full writes at wr_ptr and increments wr_ptr. endline commits.
  - Commit: the entry written with endline, or the last written entry when endline has no tag, gets last=1. commit_ptr <= wr_ptr (post-write). sentence_count increments. State returns to IDLE.
  - tag_valid while full sets overflow and moves to DROP. The word is discarded.
  - DROP: tag_valid is ignored. On endline, wr_ptr <= commit_ptr, sent_dropped pulses, and state returns to IDLE.
  - error high in any non-IDLE state, or with tag_valid in IDLE: wr_ptr <= commit_ptr, the tag of that cycle is discarded, sent_dropped pulses, state returns to IDLE.
- Priority: error over endline over tag_valid. error with endline in the same cycle is an abort, not a commit.
- Read side:
  - rd_valid = (rd_ptr != commit_ptr). It is a combinational compare of registered pointers.
  - rd_key, rd_pos and rd_last are an asynchronous read at rd_ptr.
  - A pop (rd_valid & rd_ready) increments rd_ptr.
  - Popping an entry with last=1 decrements sentence_count.
  - A commit and a last-entry pop in the same cycle leave sentence_count unchanged.
  - rd_ready while rd_valid=0 is ignored.
- Latency: an entry committed on edge N is visible (rd_valid=1) in the cycle after edge N.
- Writes and reads proceed concurrently. A pop in the same cycle as a write frees space only from the next cycle; full is evaluated on registered pointers.
- Wrap-around: pointer MSB distinguishes full from empty. Sentences may straddle the physical end of storage.
- A sentence longer than DEPTH minus the unread entries always overflows, even if the reader drains concurrently too slowly. This is accepted behaviour.

Test Plan:
- Reset then 3 tags (key 1/2/3, POS 4/5/6), endline on the 3rd, with rd_ready=1 -> rd_valid rises the cycle after the 3rd write; reads 1/4, 2/5, 3/6 with rd_last only on key 3; sentence_count goes 0→1→0.
- Tags key 7, 8, then error in the next cycle, then endline -> sent_dropped one-cycle pulse; rd_valid stays 0; sentence_count stays 0; a following 1-word sentence (key 9) reads back correctly.
- rd_ready=0, 17 tags with endline on the 17th (DEPTH=16) -> overflow=1 at the 17th; sent_dropped on endline; rd_valid=0; buffer empty.
- Three 6-word sentences with a slow reader (rd_ready every 3rd cycle) -> pointers wrap; all 18 entries are read in order with rd_last on words 6/12/18; no overflow.
- error and endline in the same cycle as the final tag -> abort: no commit, sent_dropped=1, sentence_count unchanged.
- Assert reset mid-COLLECT with 1 committed sentence unread -> all outputs return to reset values immediately (async) and stay there until reset is deasserted.
